// File: rtl/pipe_pkg.sv
// pipe_pkg: sequencer state encoding and the pipeline control words it selects between.
package pipe_pkg;
    typedef enum logic [2:0] {RUN, LU_STALL, MEM_WAIT, DRAIN, HALTED} state_t;

    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic ifid_flush;
        logic idex_bubble;
        logic exmem_flush;
        logic pipe_freeze;
        logic halted;
    } ctrl_t;

    localparam ctrl_t CTRL_RUN    = '{pc_we: 1'b1, ifid_we: 1'b1, default: 1'b0};
    localparam ctrl_t CTRL_FREEZE = '{pipe_freeze: 1'b1, default: 1'b0};
    localparam ctrl_t CTRL_STALL  = '{idex_bubble: 1'b1, default: 1'b0};
    // Branch flush: NOP into IF/ID, ID/EX and EX/MEM while the PC loads the target
    localparam ctrl_t CTRL_FLUSH  = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b1,
                                      idex_bubble: 1'b1, exmem_flush: 1'b1, default: 1'b0};
    localparam ctrl_t CTRL_DRAIN  = '{ifid_we: 1'b1, ifid_flush: 1'b1, default: 1'b0};
    localparam ctrl_t CTRL_HALT   = '{pipe_freeze: 1'b1, halted: 1'b1, default: 1'b0};
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (inc && !(&cnt))
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: 5-stage pipeline sequencer for stalls, memory waits, branch flushes and halt.
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned LU_CYCLES = 1,
    parameter int unsigned DRAIN_CYC = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             lu_stall,
    input  logic             br_taken,
    input  logic             dmem_busy,
    input  logic             halt_req,
    input  logic             resume,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_flush,
    output logic             pipe_freeze,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    state_t     state, next_state;
    logic [3:0] cnt, next_cnt;
    ctrl_t      ctrl;
    logic       flush_ev;
    logic       stall_ev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        case (state)
            RUN: begin
                if (dmem_busy) begin
                    next_state = MEM_WAIT;
                end else if (br_taken) begin
                    next_state = RUN;
                end else if (lu_stall) begin
                    next_state = (LU_CYCLES > 1) ? LU_STALL : RUN;
                    next_cnt   = 4'(LU_CYCLES - 1);
                end else if (halt_req) begin
                    next_state = DRAIN;
                    next_cnt   = 4'(DRAIN_CYC);
                end
            end
            LU_STALL: begin
                if (dmem_busy) begin
                    next_state = MEM_WAIT;
                end else if (br_taken) begin
                    next_state = RUN;
                end else begin
                    next_cnt   = cnt - 1'b1;
                    next_state = (cnt == 4'd1) ? RUN : LU_STALL;
                end
            end
            MEM_WAIT: next_state = dmem_busy ? MEM_WAIT : RUN;
            DRAIN: begin
                if (!dmem_busy) begin
                    next_cnt   = cnt - 1'b1;
                    next_state = (cnt == 4'd1) ? HALTED : DRAIN;
                end
            end
            HALTED:   next_state = resume ? RUN : HALTED;
            default:  next_state = RUN;
        endcase
    end

    always_comb begin
        ctrl     = CTRL_RUN;
        flush_ev = 1'b0;
        case (state)
            RUN: begin
                if (dmem_busy) begin
                    ctrl = CTRL_FREEZE;
                end else if (br_taken) begin
                    ctrl     = CTRL_FLUSH;
                    flush_ev = 1'b1;
                end else if (lu_stall) begin
                    ctrl = CTRL_STALL;
                end else if (halt_req) begin
                    ctrl = CTRL_DRAIN;
                end
            end
            LU_STALL: begin
                ctrl     = dmem_busy ? CTRL_FREEZE : br_taken ? CTRL_FLUSH : CTRL_STALL;
                flush_ev = !dmem_busy && br_taken;
            end
            MEM_WAIT: ctrl = dmem_busy ? CTRL_FREEZE : CTRL_RUN;
            DRAIN:    ctrl = dmem_busy ? CTRL_FREEZE : CTRL_DRAIN;
            HALTED:   ctrl = CTRL_HALT;
            default:  ctrl = CTRL_RUN;
        endcase
    end

    assign pc_we       = ctrl.pc_we;
    assign ifid_we     = ctrl.ifid_we;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_bubble = ctrl.idex_bubble;
    assign exmem_flush = ctrl.exmem_flush;
    assign pipe_freeze = ctrl.pipe_freeze;
    assign halted      = ctrl.halted;
    assign stall_ev    = !ctrl.pc_we && (state != HALTED) && !flush_ev;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (stall_ev),
        .cnt     (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (flush_ev),
        .cnt     (flush_cnt)
    );
endmodule
